// File: rtl/regfile_reader.sv
// rtl/regfile_reader.sv - burst read sequencer for regfile, valid/ready word stream out
// Optional abort port enabled by defining REGFILE_READER_ABORT_EN.
module regfile_reader #(
   parameter int size  = 16,
   parameter int width = 8,
   localparam int AW   = $clog2(size),
   localparam int CW   = $clog2(size + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [AW-1:0]    first_idx,
   input  logic [CW-1:0]    count,
`ifdef REGFILE_READER_ABORT_EN
   input  logic             abort,
`endif
   output logic [AW-1:0]    rf_readSel,
   input  logic [width-1:0] rf_outdata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] out_data,
   output logic [AW-1:0]    out_idx,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]    rem_q, rem_d;
   logic             out_valid_q, out_valid_d;
   logic [width-1:0] out_data_q, out_data_d;
   logic [AW-1:0]    out_idx_q, out_idx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             load;
   logic [AW-1:0]    first_mod;
   logic [CW-1:0]    count_clamp;
   logic [AW-1:0]    ptr_next;

   // first_idx < 2*size always holds, so a single subtraction reduces it
   always_comb begin
      if ({1'b0, first_idx} >= (AW+1)'(size)) first_mod = first_idx - AW'(size);
      else                                    first_mod = first_idx;
      count_clamp = (count > CW'(size)) ? CW'(size) : count;
      ptr_next    = (ptr_q == AW'(size - 1)) ? '0 : ptr_q + AW'(1);
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      load        = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (count != '0) begin
                  ptr_d   = first_mod;
                  rem_d   = count_clamp;
                  busy_d  = 1'b1;
                  state_d = FETCH;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         FETCH: begin
            load    = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               if (rem_q != '0) begin
                  load = 1'b1;
               end else begin
                  out_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         out_data_d  = rf_outdata;
         out_idx_d   = ptr_q;
         out_valid_d = 1'b1;
         ptr_d       = ptr_next;
         rem_d       = rem_q - CW'(1);
      end

`ifdef REGFILE_READER_ABORT_EN
      // abort beats a same-cycle handshake; that word is dropped
      if (busy_q && abort) begin
         out_valid_d = 1'b0;
         busy_d      = 1'b0;
         rem_d       = '0;
         done_d      = 1'b0;
         state_d     = IDLE;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         rem_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign rf_readSel = ptr_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_idx    = out_idx_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_regfile_reader.sv
// tb/tb_regfile_reader.sv - scoreboard bench for regfile_reader (abort tests under REGFILE_READER_ABORT_EN)
module tb_regfile_reader;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] first_idx;
   logic [4:0] count;
   logic       abort;
   logic [3:0] rf_readSel;
   logic [7:0] rf_outdata;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] out_idx;
   logic       busy;
   logic       done;

   logic [7:0] rf_mem [16];
   assign rf_outdata = rf_mem[rf_readSel];

   regfile_reader #(.size(16), .width(8)) dut (
      .clock(clock), .reset(reset), .start(start),
      .first_idx(first_idx), .count(count),
`ifdef REGFILE_READER_ABORT_EN
      .abort(abort),
`endif
      .rf_readSel(rf_readSel), .rf_outdata(rf_outdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int errors  = 0;
   int cyc = 0;
   int done_cnt = 0;
   int exp_done = 0;
   int done_cyc = 0;
   int last_hs_cyc = 0;
   int first_hs_cyc = -1;
   int valid_seen = 0;
   logic [11:0] exp_q [$];

   logic       held_valid = 1'b0;
   logic [7:0] held_d;
   logic [3:0] held_i;
   logic       hs;
   logic [11:0] item;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // monitor: pops the scoreboard on every accepted word
   always @(negedge clock) begin
      hs = out_valid && out_ready && reset;
`ifdef REGFILE_READER_ABORT_EN
      if (abort) hs = 1'b0;
`endif
      if (out_valid) valid_seen++;
      if (held_valid && out_valid) begin
         check("hold_data", {24'd0, out_data}, {24'd0, held_d});
         check("hold_idx", {28'd0, out_idx}, {28'd0, held_i});
      end
      held_valid = out_valid && !out_ready;
      held_d = out_data;
      held_i = out_idx;
      if (hs) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", {20'd0, out_idx, out_data}, 32'hFFFF_FFFF);
         end else begin
            item = exp_q.pop_front();
            check("word_idx", {28'd0, out_idx}, {28'd0, item[11:8]});
            check("word_data", {24'd0, out_data}, {24'd0, item[7:0]});
         end
         if (first_hs_cyc < 0) first_hs_cyc = cyc;
         last_hs_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic push(input int idx, input logic [7:0] data);
      exp_q.push_back({4'(idx), data});
   endtask

   task automatic start_burst(input int f, input int c);
      first_idx = 4'(f);
      count     = 5'(c);
      start     = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (done_cnt < exp_done && k < budget) begin
         @(posedge clock);
         #1 k++;
      end
      check("done_count", done_cnt, exp_done);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rf_mem[i] = 8'hA0 + 8'(i);
      reset = 1'b0; start = 1'b0; first_idx = '0; count = '0;
      abort = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_valid", {31'd0, out_valid}, 0);
      check("rst_data", {24'd0, out_data}, 0);
      check("rst_idx", {28'd0, out_idx}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_sel", {28'd0, rf_readSel}, 0);
      @(posedge clock);
      #1 reset = 1'b1;

      // basic burst, latency and back-to-back timing
      push(2, 8'hA2); push(3, 8'hA3); push(4, 8'hA4); push(5, 8'hA5);
      first_hs_cyc = -1;
      exp_done++;
      start_burst(2, 4);
      @(negedge clock);
      check("lat_fetch_valid", {31'd0, out_valid}, 0);
      check("lat_busy", {31'd0, busy}, 1);
      @(negedge clock);
      check("lat_first_valid", {31'd0, out_valid}, 1);
      @(posedge clock); #1;
      wait_done(20);
      check("b2b_span", last_hs_cyc - first_hs_cyc, 3);
      check("done_after_last", done_cyc, last_hs_cyc + 1);

      // wrap-around
      push(14, 8'hAE); push(15, 8'hAF); push(0, 8'hA0); push(1, 8'hA1);
      exp_done++;
      start_burst(14, 4);
      wait_done(20);

      // ready toggling plus write-after-fetch coherence
      push(9, 8'hA9); push(10, 8'hAA); push(11, 8'hAB);
      exp_done++;
      out_ready = 1'b0;
      start_burst(9, 3);
      @(posedge clock);
      #1 rf_mem[9] = 8'h55;
      for (int k = 0; k < 30 && done_cnt < exp_done; k++) begin
         out_ready = (k % 3 == 2);
         @(posedge clock);
         #1;
      end
      out_ready = 1'b1;
      rf_mem[9] = 8'hA9;
      check("toggle_done", done_cnt, exp_done);

      // count = 0
      valid_seen = 0;
      exp_done++;
      start_burst(4, 0);
      @(negedge clock);
      check("cnt0_done", {31'd0, done}, 1);
      repeat (3) @(posedge clock);
      #1 check("cnt0_novalid", valid_seen, 0);
      check("cnt0_done_count", done_cnt, exp_done);

      // count > size clamps to size
      for (int i = 0; i < 16; i++) push((3 + i) % 16, 8'hA0 + 8'((3 + i) % 16));
      exp_done++;
      start_burst(3, 20);
      wait_done(40);

      // start held high through the burst
      push(5, 8'hA5); push(6, 8'hA6); push(7, 8'hA7); push(8, 8'hA8);
      exp_done++;
      first_idx = 4'd5; count = 5'd4; start = 1'b1;
      repeat (3) @(posedge clock);
      #1 start = 1'b0;
      wait_done(20);

      // reset in HOLD with 2 words remaining
      push(0, 8'hA0);
      start_burst(0, 4);
      repeat (2) @(posedge clock);
      #1 out_ready = 1'b0; reset = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      out_ready = 1'b1;
      check("mid_rst_valid", {31'd0, out_valid}, 0);
      check("mid_rst_busy", {31'd0, busy}, 0);
      check("mid_rst_done", {31'd0, done}, 0);
      repeat (3) @(posedge clock);
      #1 check("mid_rst_no_done", done_cnt, exp_done);

`ifdef REGFILE_READER_ABORT_EN
      // abort on the second word's handshake
      push(0, 8'hA0);
      start_burst(0, 5);
      repeat (2) @(posedge clock);
      #1 abort = 1'b1;
      @(posedge clock);
      #1 abort = 1'b0;
      check("abort_valid", {31'd0, out_valid}, 0);
      check("abort_busy", {31'd0, busy}, 0);
      repeat (3) @(posedge clock);
      #1 check("abort_no_done", done_cnt, exp_done);
      push(7, 8'hA7); push(8, 8'hA8);
      exp_done++;
      start_burst(7, 2);
      wait_done(20);
`endif

      repeat (2) @(posedge clock);
      #1 check("scoreboard_empty", exp_q.size(), 0);
      check("final_done_count", done_cnt, exp_done);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/regfile_reader.md
Name: regfile_reader

Overview:
- Read-side sequencer for the team's `regfile` block.
- On `start`, walks `count` consecutive entries beginning at `first_idx`, wrapping modulo `size`.
- Drives the register file's read select and captures its combinational read data.
- Presents each word downstream on a valid/ready stream, one word per cycle under continuous ready.

Parameters:
- size, 16, number of register file entries (any value >= 2)
- width, 8, data word width
- AW, $clog2(size), index width (derived, localparam)
- CW, $clog2(size+1), count width (derived, localparam)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- start  input  1  begin a burst; sampled only in IDLE
- first_idx  input  AW  first entry to read; values >= size are reduced modulo size
- count  input  CW  number of entries to read
- rf_readSel  output  AW  read select to regfile
- rf_outdata  input  width  combinational read data from regfile
- out_valid  output  1  out_data/out_idx hold a word
- out_ready  input  1  downstream accepts the word
- out_data  output  width  registered word
- out_idx  output  AW  index the word came from
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse when the burst completes

Behaviour:
- One clock, `clock`. `reset` is synchronous and active-low: on a rising edge with reset=0, all state is cleared.
- Values on reset: out_valid=0, out_data=0, out_idx=0, busy=0, done=0, rf_readSel=0, state=IDLE.
- Internal registers:
  - ptr (AW): next index to fetch.
  - rem (CW): words not yet fetched.
- rf_readSel = ptr at all times (registered, glitch-free).
- IDLE:
  - start=1 and count>0: ptr<=first_idx mod size; rem<=min(count,size); busy<=1; go FETCH.
  - start=1 and count=0: done<=1 for one cycle; stay IDLE; no word emitted.
- FETCH (one cycle):
  - out_data<=rf_outdata; out_idx<=ptr; out_valid<=1.
  - ptr<=(ptr==size-1)?0:ptr+1; rem<=rem-1; go HOLD.
- HOLD:
  - out_valid=1, out_ready=0: out_data/out_idx held stable; no state change.
  - out_valid=1, out_ready=1, rem>0: load next word exactly as FETCH does; stay HOLD; out_valid stays 1 (back-to-back, 1 word/cycle).
  - out_valid=1, out_ready=1, rem=0: out_valid<=0; busy<=0; done<=1 next cycle; go IDLE.
- Latency: first word valid 2 cycles after the start edge (IDLE->FETCH->HOLD).
- Burst duration: N words with constant ready take N+1 cycles from FETCH to done.
- Wrap-around: indices wrap size-1 -> 0 for any size, not only powers of two.
- count > size: clamped to size, so each entry is read once.
- start while busy: ignored.
- done and start in the same IDLE cycle: new burst accepted normally.
- Data coherence: words reflect regfile contents at the fetch cycle. A write to an entry after its fetch is not seen.
- reset=0 mid-burst: burst abandoned; all outputs return to reset values at that edge; no done pulse.

Optional Feature:
- REGFILE_READER_ABORT_EN defined:
  - Adds port `abort  input  1`.
  - When busy=1 and abort=1 at an edge: out_valid<=0, busy<=0, rem<=0, go IDLE; no done pulse.
  - abort has priority over a same-cycle out_valid&out_ready handshake; that word counts as not transferred.
  - abort in IDLE is ignored.
- REGFILE_READER_ABORT_EN undefined: no abort port; bursts end only by completion or reset.

Test Plan:
- Regfile preloaded entry i = 8'hA0+i; start, first_idx=2, count=4, out_ready=1 -> out_idx 2,3,4,5 with out_data A2..A5 on consecutive cycles; first valid 2 cycles after start; done one cycle after last handshake.
- first_idx=14, count=4, size=16 -> out_idx 14,15,0,1; out_data AE,AF,A0,A1.
- out_ready toggled 1,0,0,1,... during count=3 -> out_data/out_idx stable while ready=0; exactly 3 transfers; done once.
- count=0 -> done pulse the cycle after start; out_valid never 1. count=20 with size=16 -> exactly 16 words, indices first_idx..first_idx+15 mod 16.
- reset=0 while in HOLD with 2 words remaining -> next cycle out_valid=0, busy=0, done=0. start held high during a burst -> no restart, burst ordering unchanged.
- With REGFILE_READER_ABORT_EN: abort=1 coincident with a handshake on word 2 of 5 -> out_valid=0 next cycle, busy=0, no done. A following start runs a clean burst.
